l1an_rdo_seq: RTL and testbench
===============================

// Module: l1an_rdo_seq
// PURPOSE
//  Sequencer for the L1A-number FIFO: pushes one entry per matched L1A and pops one per event readout.
//  Presents the head L1A number and phase to the readout formatter with a valid/ack handshake.
//  Releases the head only when the sample buffer reports that the event's data is complete.
//  Sits between trigger logic (L1A_MATCH), the L1A-number FIFO and the readout/header path.
// PARAMETERS
//  TMR     0  1 = triplicated state/counter registers with voters; no change to cycle behaviour
//  SETTLE  2  cycles waited after the head becomes eligible before capturing the FIFO output (>=2)
//  CRED_W  4  width of the event-ready credit counter
// PORTS
//  CLK          in   1  system clock; all logic on rising edge
//  RST          in   1  synchronous reset, active-high
//  L1A_MATCH    in   1  one-cycle pulse: matched L1A, enqueue DL1AN/L1A_PHASE
//  EVT_RDY      in   1  one-cycle pulse: one event's samples complete in the buffer
//  FIFO_EMPTY   in   1  FIFO empty flag (registered in the FIFO)
//  FIFO_FULL    in   1  FIFO full flag (registered in the FIFO)
//  FIFO_L1ANUM  in   6  FIFO read data: L1A number at the head
//  FIFO_PHASE   in   1  FIFO read data: L1A phase at the head
//  FIFO_PUSH    out  1  FIFO write strobe
//  FIFO_POP     out  1  FIFO read-advance strobe
//  HDR_VALID    out  1  head entry valid for the formatter
//  HDR_L1ANUM   out  6  captured L1A number
//  HDR_PHASE    out  1  captured L1A phase
//  HDR_ACK      in   1  formatter accepted the header (counts only while HDR_VALID=1)
//  BUSY         out  1  1 in every state other than IDLE
//  OVFL         out  1  sticky: L1A_MATCH arrived while FIFO_FULL=1
//  DROP_CNT     out  8  saturating count of dropped L1A_MATCH (stops at 8'hFF)
//  CRED_ERR     out  1  sticky: EVT_RDY arrived with credits at the maximum
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, credits 0. FIFO_PUSH is also forced 0 while RST=1.
//  RST mid-operation: the sequencer returns to IDLE on the next edge and HDR_VALID drops.
//  The FIFO is reset by the same RST.
//  Push: FIFO_PUSH = L1A_MATCH & ~FIFO_FULL & ~RST (combinational, same cycle as the pulse).
//  Drop: L1A_MATCH with FIFO_FULL=1 -> no push; OVFL<=1 and DROP_CNT+1 (saturating), both at the next edge.
//  Credits: +1 on EVT_RDY, -1 on the POP state.
//  Credits: EVT_RDY in the POP cycle -> net unchanged.
//  Credits: EVT_RDY at max (2^CRED_W-1) -> value held, CRED_ERR<=1.
//  FSM (registered; FIFO_POP is a registered state decode):
//   IDLE:    if ~FIFO_EMPTY & credits!=0 -> WAIT and load settle counter = SETTLE-1; otherwise stay.
//   WAIT:    counter decrements. At 0 -> capture FIFO_L1ANUM/FIFO_PHASE into HDR_*, set HDR_VALID, go to PRESENT.
//            Purpose: cover the 1-cycle RAM read latency and a write/read address collision.
//   PRESENT: hold HDR_VALID and HDR_* stable. On HDR_ACK -> HDR_VALID<=0, go to POP.
//   POP:     FIFO_POP=1 for exactly one cycle, credits -1, go to GAP.
//   GAP:     one cycle so that FIFO_EMPTY and the read address update, then go to IDLE.
//  Latency: eligible head (EMPTY low, credit>0) -> HDR_VALID high in 1+SETTLE cycles.
//  Latency: HDR_ACK -> FIFO_POP high at the next edge. Minimum spacing between events is SETTLE+4 cycles.
//  HDR_ACK outside PRESENT is ignored.
//  FIFO_FULL/FIFO_EMPTY are trusted as given; the sequencer never pops while FIFO_EMPTY=1.
//  Simultaneous L1A_MATCH and POP: both are performed; the FIFO handles the concurrent push/pop.
// STRUCTURE
//  Shared package: state encoding (IDLE, WAIT, PRESENT, POP, GAP) and L1AN_W=6.
//  Counters (settle, credit, drop) use the existing TMR-capable counter primitives with TMR passed through.
//  TMR=1: FSM state registers are triplicated and voted with the existing vote module.
//  One sub-module: l1an_credit_cnt (up/down saturating credit counter with error flag).
// TESTING
//  1 Single event: MATCH with DL1AN=6'h15, phase=1; EVT_RDY 5 cycles later.
//    -> HDR_VALID after 1+SETTLE cycles with HDR_L1ANUM=6'h15, HDR_PHASE=1.
//    -> ACK -> one FIFO_POP pulse, then IDLE and BUSY=0.
//  2 Back-to-back: 3 MATCH (6'h01,6'h02,6'h03), then 3 EVT_RDY; ACK every header immediately.
//    -> headers appear in order 01,02,03 exactly SETTLE+4 cycles apart; 3 pops total.
//  3 Data not ready: 2 MATCH and no EVT_RDY for 50 cycles -> HDR_VALID stays 0, BUSY=0.
//    -> after one EVT_RDY, exactly one header is issued.
//  4 Overflow: fill the FIFO to FULL, then 300 more MATCH pulses -> FIFO_PUSH never asserted.
//    -> OVFL=1, DROP_CNT=8'hFF (saturated).
//  5 Credit limit with CRED_W=4: 16 EVT_RDY with an empty FIFO -> credits=15, CRED_ERR=1.
//    -> with an EVT_RDY coincident with POP, the credit value is unchanged.
//  6 Reset mid-PRESENT: assert RST for 1 cycle while HDR_VALID=1.
//    -> next edge HDR_VALID=0, OVFL=0, DROP_CNT=0, BUSY=0, no FIFO_POP.

Source files
------------

// File: rtl/l1an_rdo_seq_pkg.sv
// Shared types for the L1A-number readout sequencer: FSM state encoding and field widths.
package l1an_rdo_seq_pkg;

  localparam int L1AN_W = 6;
  localparam int DROP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_PRESENT = 3'd2,
    ST_POP     = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

endpackage

// File: rtl/l1an_rdo_seq_credit_cnt.sv
// Up/down event-ready credit counter; saturates at all-ones and flags a lost increment (sticky).
module l1an_credit_cnt #(
  parameter int TMR    = 0,
  parameter int CRED_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [CRED_W-1:0] cnt_o,
  output logic              err_o
);

  localparam logic [CRED_W-1:0] CRED_MAX = '1;

  logic [CRED_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  // Simultaneous inc/dec cancel; the error only fires when an increment is actually lost.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == CRED_MAX) err_d = 1'b1;
      else                   cnt_d = cnt_q + CRED_W'(1);
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - CRED_W'(1);
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      logic [CRED_W-1:0] r0_q, r1_q, r2_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r0_q <= '0;
          r1_q <= '0;
          r2_q <= '0;
        end else begin
          r0_q <= cnt_d;
          r1_q <= cnt_d;
          r2_q <= cnt_d;
        end
      end
      assign cnt_q = (r0_q & r1_q) | (r0_q & r2_q) | (r1_q & r2_q);
    end else begin : g_plain
      logic [CRED_W-1:0] r0_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) r0_q <= '0;
        else       r0_q <= cnt_d;
      end
      assign cnt_q = r0_q;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/l1an_rdo_seq.sv
// L1A-number FIFO sequencer: pushes on matched L1A, presents the head once its event data is complete,
// holds it until the formatter acks, then pops. Header valid 1+SETTLE cycles after the head is eligible.
module l1an_rdo_seq
  import l1an_rdo_seq_pkg::*;
#(
  parameter int TMR    = 0,
  parameter int SETTLE = 2,
  parameter int CRED_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              l1a_match_i,
  input  logic              evt_rdy_i,
  input  logic              fifo_empty_i,
  input  logic              fifo_full_i,
  input  logic [L1AN_W-1:0] fifo_l1anum_i,
  input  logic              fifo_phase_i,
  output logic              fifo_push_o,
  output logic              fifo_pop_o,
  output logic              hdr_valid_o,
  output logic [L1AN_W-1:0] hdr_l1anum_o,
  output logic              hdr_phase_o,
  input  logic              hdr_ack_i,
  output logic              busy_o,
  output logic              ovfl_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              cred_err_o
);

  localparam int SW = $clog2(SETTLE);
  localparam int TW = 3 + SW + DROP_W;

  state_t              state_q, state_d;
  logic [2:0]          state_raw;
  logic [SW-1:0]       settle_q, settle_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [TW-1:0]       tmr_q, tmr_d;

  logic                hdr_valid_q, hdr_valid_d;
  logic [L1AN_W-1:0]   hdr_l1anum_q, hdr_l1anum_d;
  logic                hdr_phase_q, hdr_phase_d;
  logic                ovfl_q, ovfl_d;
  logic [CRED_W-1:0]   cred_cnt;

  // State, settle counter and drop counter share one protected register bank.
  assign tmr_d = {state_d, settle_d, drop_d};
  assign {state_raw, settle_q, drop_q} = tmr_q;
  assign state_q = state_t'(state_raw);

  generate
    if (TMR != 0) begin : g_tmr
      logic [TW-1:0] r0_q, r1_q, r2_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r0_q <= '0;
          r1_q <= '0;
          r2_q <= '0;
        end else begin
          r0_q <= tmr_d;
          r1_q <= tmr_d;
          r2_q <= tmr_d;
        end
      end
      assign tmr_q = (r0_q & r1_q) | (r0_q & r2_q) | (r1_q & r2_q);
    end else begin : g_plain
      logic [TW-1:0] r0_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) r0_q <= '0;
        else       r0_q <= tmr_d;
      end
      assign tmr_q = r0_q;
    end
  endgenerate

  l1an_credit_cnt #(
    .TMR    (TMR),
    .CRED_W (CRED_W)
  ) u_cred (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (evt_rdy_i),
    .dec_i (fifo_pop_o),
    .cnt_o (cred_cnt),
    .err_o (cred_err_o)
  );

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    drop_d       = drop_q;
    hdr_valid_d  = hdr_valid_q;
    hdr_l1anum_d = hdr_l1anum_q;
    hdr_phase_d  = hdr_phase_q;
    ovfl_d       = ovfl_q;

    if (l1a_match_i && fifo_full_i) begin
      ovfl_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_i && cred_cnt != '0) begin
          state_d  = ST_WAIT;
          settle_d = SW'(SETTLE - 1);
        end
      end
      // Settling covers RAM read latency and a same-address write/read collision.
      ST_WAIT: begin
        if (settle_q == '0) begin
          hdr_l1anum_d = fifo_l1anum_i;
          hdr_phase_d  = fifo_phase_i;
          hdr_valid_d  = 1'b1;
          state_d      = ST_PRESENT;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_PRESENT: begin
        if (hdr_ack_i) begin
          hdr_valid_d = 1'b0;
          state_d     = ST_POP;
        end
      end
      ST_POP:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_valid_q  <= 1'b0;
      hdr_l1anum_q <= '0;
      hdr_phase_q  <= 1'b0;
      ovfl_q       <= 1'b0;
    end else begin
      hdr_valid_q  <= hdr_valid_d;
      hdr_l1anum_q <= hdr_l1anum_d;
      hdr_phase_q  <= hdr_phase_d;
      ovfl_q       <= ovfl_d;
    end
  end

  assign fifo_push_o  = l1a_match_i & ~fifo_full_i & ~rst_i;
  assign fifo_pop_o   = (state_q == ST_POP);
  assign busy_o       = (state_q != ST_IDLE);
  assign hdr_valid_o  = hdr_valid_q;
  assign hdr_l1anum_o = hdr_l1anum_q;
  assign hdr_phase_o  = hdr_phase_q;
  assign ovfl_o       = ovfl_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_l1an_rdo_seq.sv
// Directed bench for l1an_rdo_seq with a small behavioural L1A-number FIFO (registered flags and read data).
`timescale 1ns/1ps
module tb_l1an_rdo_seq;

  localparam int SETTLE = 2;
  localparam int CRED_W = 4;
  localparam int DEPTH  = 8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, l1a_match, evt_rdy, hdr_ack, dphase;
  logic [5:0] dl1an;
  logic       fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_phase;
  logic [5:0] fifo_l1anum, hdr_l1anum;
  logic       hdr_valid, hdr_phase, busy, ovfl, cred_err;
  logic [7:0] drop_cnt;

  int checks = 0, failures = 0, push_cnt = 0, pop_cnt = 0, fcnt = 0;

  l1an_rdo_seq #(.TMR(0), .SETTLE(SETTLE), .CRED_W(CRED_W)) dut (
    .clk_i(clk), .rst_i(rst), .l1a_match_i(l1a_match), .evt_rdy_i(evt_rdy),
    .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full),
    .fifo_l1anum_i(fifo_l1anum), .fifo_phase_i(fifo_phase),
    .fifo_push_o(fifo_push), .fifo_pop_o(fifo_pop),
    .hdr_valid_o(hdr_valid), .hdr_l1anum_o(hdr_l1anum), .hdr_phase_o(hdr_phase),
    .hdr_ack_i(hdr_ack), .busy_o(busy), .ovfl_o(ovfl), .drop_cnt_o(drop_cnt),
    .cred_err_o(cred_err)
  );

  logic [6:0] mem [DEPTH];
  logic [2:0] wp, rp;
  logic [6:0] rd_q;

  always @(posedge clk) begin
    if (fifo_push) push_cnt <= push_cnt + 1;
    if (fifo_pop)  pop_cnt  <= pop_cnt + 1;
    if (rst) begin
      wp   <= 3'd0;
      rp   <= 3'd0;
      fcnt <= 0;
      rd_q <= 7'd0;
    end else begin
      if (fifo_push) begin
        mem[wp] <= {dphase, dl1an};
        wp      <= wp + 3'd1;
      end
      if (fifo_pop) rp <= rp + 3'd1;
      fcnt <= fcnt + (fifo_push ? 1 : 0) - (fifo_pop ? 1 : 0);
      rd_q <= mem[rp];
    end
  end

  assign fifo_empty  = (fcnt == 0);
  assign fifo_full   = (fcnt == DEPTH);
  assign fifo_l1anum = rd_q[5:0];
  assign fifo_phase  = rd_q[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; l1a_match = 1'b0; evt_rdy = 1'b0; hdr_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; l1a_match = 1'b0; evt_rdy = 1'b0; hdr_ack = 1'b0; dl1an = 6'h0; dphase = 1'b0;
    tick(); tick();
    l1a_match = 1'b1;
    #1;
    checks++; if (fifo_push !== 1'b0) begin failures++; $display("FAIL reset_push got=%b exp=0", fifo_push); end
    checks++; if (hdr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", hdr_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_pop !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b exp=0", fifo_pop); end
    checks++; if (ovfl !== 1'b0 || cred_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ovfl, cred_err); end
    checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL reset_drop got=%h exp=00", drop_cnt); end
    checks++; if (hdr_l1anum !== 6'h00 || hdr_phase !== 1'b0) begin failures++; $display("FAIL reset_hdr got=%h/%b exp=00/0", hdr_l1anum, hdr_phase); end
    checks++; if (dut.cred_cnt !== 4'd0) begin failures++; $display("FAIL reset_cred got=%0d exp=0", dut.cred_cnt); end
    l1a_match = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int rise_k, p0;
    do_reset();
    p0 = pop_cnt; rise_k = 0;
    l1a_match = 1'b1; dl1an = 6'h15; dphase = 1'b1;
    #1;
    checks++; if (fifo_push !== 1'b1) begin failures++; $display("FAIL single_push got=%b exp=1", fifo_push); end
    tick();
    l1a_match = 1'b0;
    repeat (4) tick();
    evt_rdy = 1'b1; tick(); evt_rdy = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (hdr_valid === 1'b1) begin rise_k = k; break; end
    end
    checks++; if (rise_k != SETTLE + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", rise_k, SETTLE + 1); end
    checks++; if (hdr_l1anum !== 6'h15 || hdr_phase !== 1'b1) begin failures++; $display("FAIL single_hdr got=%h/%b exp=15/1", hdr_l1anum, hdr_phase); end
    hdr_ack = 1'b1;
    tick();
    hdr_ack = 1'b0;
    checks++; if (fifo_pop !== 1'b1 || hdr_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=pop%b/valid%b exp=pop1/valid0", fifo_pop, hdr_valid); end
    tick();
    checks++; if (fifo_pop !== 1'b0) begin failures++; $display("FAIL single_pop_width got=%b exp=0", fifo_pop); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
    checks++; if (pop_cnt - p0 != 1) begin failures++; $display("FAIL single_popcnt got=%0d exp=1", pop_cnt - p0); end
  endtask

  task automatic test_back_to_back();
    int         rise_t [3];
    logic [5:0] rise_v [3];
    int         n, p0;
    logic       prev;
    do_reset();
    p0 = pop_cnt; n = 0; prev = 1'b0;
    for (int i = 0; i < 3; i++) begin rise_t[i] = 0; rise_v[i] = 6'h3F; end
    for (int i = 0; i < 3; i++) begin
      l1a_match = 1'b1; dl1an = 6'(i + 1); dphase = 1'b0;
      tick();
    end
    l1a_match = 1'b0;
    hdr_ack = 1'b1;
    for (int t = 0; t < 60; t++) begin
      evt_rdy = (t < 3);
      tick();
      if (hdr_valid === 1'b1 && !prev) begin
        if (n < 3) begin rise_t[n] = t; rise_v[n] = hdr_l1anum; end
        n++;
      end
      prev = hdr_valid;
    end
    evt_rdy = 1'b0; hdr_ack = 1'b0;
    checks++; if (n != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
    checks++; if (rise_v[0] !== 6'h01 || rise_v[1] !== 6'h02 || rise_v[2] !== 6'h03) begin
      failures++; $display("FAIL b2b_order got=%h,%h,%h exp=01,02,03", rise_v[0], rise_v[1], rise_v[2]); end
    checks++; if (rise_t[1] - rise_t[0] != SETTLE + 4 || rise_t[2] - rise_t[1] != SETTLE + 4) begin
      failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=%0d", rise_t[1] - rise_t[0], rise_t[2] - rise_t[1], SETTLE + 4); end
    checks++; if (pop_cnt - p0 != 3) begin failures++; $display("FAIL b2b_pops got=%0d exp=3", pop_cnt - p0); end
  endtask

  task automatic test_not_ready();
    logic seen_valid, seen_busy, prev;
    int   n, p0;
    do_reset();
    seen_valid = 1'b0; seen_busy = 1'b0; prev = 1'b0; n = 0;
    for (int i = 0; i < 2; i++) begin
      l1a_match = 1'b1; dl1an = 6'(8 + i); dphase = 1'b0;
      tick();
    end
    l1a_match = 1'b0;
    for (int t = 0; t < 50; t++) begin
      tick();
      seen_valid |= hdr_valid;
      seen_busy  |= busy;
    end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL notrdy_valid got=%b exp=0", seen_valid); end
    checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL notrdy_busy got=%b exp=0", seen_busy); end
    p0 = pop_cnt;
    hdr_ack = 1'b1;
    evt_rdy = 1'b1; tick(); evt_rdy = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (hdr_valid === 1'b1 && !prev) n++;
      prev = hdr_valid;
    end
    hdr_ack = 1'b0;
    checks++; if (n != 1) begin failures++; $display("FAIL notrdy_headers got=%0d exp=1", n); end
    checks++; if (pop_cnt - p0 != 1) begin failures++; $display("FAIL notrdy_pops got=%0d exp=1", pop_cnt - p0); end
  endtask

  task automatic test_overflow();
    int p0;
    do_reset();
    p0 = push_cnt;
    l1a_match = 1'b1; dl1an = 6'h2C; dphase = 1'b1;
    repeat (DEPTH) tick();
    checks++; if (fifo_full !== 1'b1 || push_cnt - p0 != DEPTH) begin
      failures++; $display("FAIL ovf_fill got=full%b/pushes%0d exp=full1/pushes%0d", fifo_full, push_cnt - p0, DEPTH); end
    checks++; if (ovfl !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b exp=0", ovfl); end
    p0 = push_cnt;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (drop_cnt !== 8'h01 || ovfl !== 1'b1) begin
          failures++; $display("FAIL ovf_first got=%h/%b exp=01/1", drop_cnt, ovfl); end
      end
    end
    l1a_match = 1'b0;
    tick();
    checks++; if (push_cnt - p0 != 0) begin failures++; $display("FAIL ovf_push got=%0d exp=0", push_cnt - p0); end
    checks++; if (drop_cnt !== 8'hFF || ovfl !== 1'b1) begin failures++; $display("FAIL ovf_sat got=%h/%b exp=ff/1", drop_cnt, ovfl); end
  endtask

  task automatic test_credit_limit();
    logic found;
    do_reset();
    evt_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 14) begin
        checks++; if (dut.cred_cnt !== 4'd15 || cred_err !== 1'b0) begin
          failures++; $display("FAIL cred_at15 got=%0d/%b exp=15/0", dut.cred_cnt, cred_err); end
      end
    end
    evt_rdy = 1'b0;
    checks++; if (dut.cred_cnt !== 4'd15 || cred_err !== 1'b1) begin
      failures++; $display("FAIL cred_sat got=%0d/%b exp=15/1", dut.cred_cnt, cred_err); end
    l1a_match = 1'b1; dl1an = 6'h2A; dphase = 1'b0;
    tick();
    l1a_match = 1'b0;
    hdr_ack = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (fifo_pop === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL cred_pop_seen got=0 exp=1"); end
    evt_rdy = 1'b1; tick(); evt_rdy = 1'b0; hdr_ack = 1'b0;
    checks++; if (dut.cred_cnt !== 4'd15) begin failures++; $display("FAIL cred_pop_coincident got=%0d exp=15", dut.cred_cnt); end
  endtask

  task automatic test_reset_mid();
    logic found;
    int   p0;
    do_reset();
    l1a_match = 1'b1; dl1an = 6'h33; dphase = 1'b1;
    repeat (DEPTH + 2) tick();
    l1a_match = 1'b0;
    checks++; if (ovfl !== 1'b1 || drop_cnt !== 8'h02) begin failures++; $display("FAIL mid_pre got=%b/%h exp=1/02", ovfl, drop_cnt); end
    evt_rdy = 1'b1; tick(); evt_rdy = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (hdr_valid === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (!found || hdr_l1anum !== 6'h33) begin failures++; $display("FAIL mid_present got=%b/%h exp=1/33", found, hdr_l1anum); end
    p0 = pop_cnt;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (hdr_valid !== 1'b0 || busy !== 1'b0 || fifo_pop !== 1'b0) begin
      failures++; $display("FAIL mid_state got=valid%b/busy%b/pop%b exp=0/0/0", hdr_valid, busy, fifo_pop); end
    checks++; if (ovfl !== 1'b0 || drop_cnt !== 8'h00) begin failures++; $display("FAIL mid_flags got=%b/%h exp=0/00", ovfl, drop_cnt); end
    repeat (4) tick();
    checks++; if (pop_cnt != p0) begin failures++; $display("FAIL mid_nopop got=%0d exp=%0d", pop_cnt, p0); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_not_ready();
    test_overflow();
    test_credit_limit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
